// File: rtl/sram_1rw_requester.sv
// Initiator-side controller for a 1RW SRAM wrapper: zero-latency issue, credit-limited reads,
// FWFT response buffer with bypass. Optional counters enabled by SRAM_REQ_STATS_EN.
module sram_1rw_requester #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 176,
    parameter int MASK_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [DATA_W-1:0] RW0_wdata,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic              RW0_en,
    output logic              RW0_wmode,
    input  logic [DATA_W-1:0] RW0_rdata
`ifdef SRAM_REQ_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_stalls
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   OCC_MAX  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    function automatic logic [PTR_W-1:0] idx_inc(input logic [PTR_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
    endfunction

    logic              rd_pending_q, rd_pending_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [DATA_W-1:0] buf_q [DEPTH];

    logic [CNT_W:0]    occ;
    logic              fire;
    logic              buf_nonempty;
    logic              push;
    logic              pop;

    // A read in flight already owns a buffer slot, so it counts against the credit.
    assign occ          = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_pending_q};
    assign req_ready    = reset_n & (occ < OCC_MAX);
    assign fire         = req_valid & req_ready;

    assign RW0_en       = fire;
    assign RW0_wmode    = fire & req_write;
    assign RW0_addr     = req_addr;
    assign RW0_wdata    = req_wdata;
    assign RW0_wmask    = req_wmask;

    assign buf_nonempty = (count_q != '0);
    assign resp_valid   = buf_nonempty | rd_pending_q;
    assign resp_rdata   = buf_nonempty ? buf_q[head_q] : RW0_rdata;

    // Macro data is only valid for one cycle; park it unless it leaves via the bypass.
    assign push         = rd_pending_q & ~(~buf_nonempty & resp_ready);
    assign pop          = buf_nonempty & resp_ready;

    always_comb begin
        rd_pending_d = fire & ~req_write;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        if (push) begin
            tail_d = idx_inc(tail_q);
        end
        if (pop) begin
            head_d = idx_inc(head_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending_q <= 1'b0;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
        end else begin
            rd_pending_q <= rd_pending_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            buf_q[tail_q] <= RW0_rdata;
        end
    end

`ifdef SRAM_REQ_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] reads_q, reads_d;
    logic [31:0] writes_q, writes_d;
    logic [31:0] stalls_q, stalls_d;

    always_comb begin
        reads_d  = reads_q;
        writes_d = writes_q;
        stalls_d = stalls_q;
        if (fire && !req_write) begin
            reads_d = sat_inc(reads_q);
        end
        if (fire && req_write) begin
            writes_d = sat_inc(writes_q);
        end
        if (req_valid && !req_ready) begin
            stalls_d = sat_inc(stalls_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reads_q  <= '0;
            writes_q <= '0;
            stalls_q <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_reads  = reads_q;
    assign stat_writes = writes_q;
    assign stat_stalls = stalls_q;
`endif

endmodule
